// File: rtl/dfm_pkg.sv
// Shared types and sizing for the measure-result write path.
// Channel count, record width and a modular channel-step helper.
package dfm_pkg;
  localparam int N_CH   = 5;
  localparam int DATA_W = 64;
  localparam int CH_W   = $clog2(N_CH);

  typedef logic [CH_W-1:0]   ch_idx_t;
  typedef logic [DATA_W-1:0] meas_rec_t;

  function automatic ch_idx_t ch_step(
    input ch_idx_t p,
    input int      k
  );
    int s;
    s = (int'(p) + k) % N_CH;
    return ch_idx_t'(s);
  endfunction
endpackage

// File: rtl/meas_wr_arbiter_if.sv
// Bundle between the measure channels and the regfile write port.
// master: measure side plus regfile sink; slave: the arbiter.
interface meas_wr_arbiter_if;
  import dfm_pkg::*;

  logic [N_CH-1:0] raw_wr_en_i;
  meas_rec_t       raw_wr_data_i [N_CH];
  logic            ovf_clr_i;
  logic            reg_wr_en_o;
  meas_rec_t       reg_wr_data_o;
  ch_idx_t         reg_wr_ch_o;
  logic [N_CH-1:0] ovf_o;

  modport master (
    output raw_wr_en_i,
    output raw_wr_data_i,
    output ovf_clr_i,
    input  reg_wr_en_o,
    input  reg_wr_data_o,
    input  reg_wr_ch_o,
    input  ovf_o
  );

  modport slave (
    input  raw_wr_en_i,
    input  raw_wr_data_i,
    input  ovf_clr_i,
    output reg_wr_en_o,
    output reg_wr_data_o,
    output reg_wr_ch_o,
    output ovf_o
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick over the pending-slot vector.
// Search starts one past the last grant and wraps.
module rr_arbiter
  import dfm_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  ch_idx_t         ptr,
  output logic [N_CH-1:0] gnt,
  output ch_idx_t         idx,
  output logic            any
);

  // First requester at or after ptr+1, wrapping
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      if (!any && req[ch_step(ptr, k)]) begin
        any = 1'b1;
        idx = ch_step(ptr, k);
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/meas_wr_arbiter.sv
// Loss-free merge of per-channel measure results onto one write port.
// One buffered record per channel, issued one per cycle round-robin.
module meas_wr_arbiter
  import dfm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  meas_wr_arbiter_if.slave  bus
);

  logic [N_CH-1:0] slot_vld;
  meas_rec_t       slot_data [N_CH];
  ch_idx_t         ptr;
  logic [N_CH-1:0] gnt;
  ch_idx_t         gnt_idx;
  logic            gnt_any;
  logic [N_CH-1:0] ovf_set;
  logic [N_CH-1:0] ovf;

  rr_arbiter u_rr (
    .req (slot_vld),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // Overflow: a capture lands on a pending slot that is not leaving
  always_comb begin
    ovf_set = bus.raw_wr_en_i & slot_vld & ~gnt;
  end

  // Slot capture; a new strobe beats a same-cycle grant
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slot_vld <= '0;
      for (int i = 0; i < N_CH; i++)
        slot_data[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.raw_wr_en_i[i]) begin
          slot_vld[i]  <= 1'b1;
          slot_data[i] <= bus.raw_wr_data_i[i];
        end else if (gnt[i]) begin
          slot_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Registered write port and round-robin pointer
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr               <= ch_idx_t'(N_CH - 1);
      bus.reg_wr_en_o   <= 1'b0;
      bus.reg_wr_data_o <= '0;
      bus.reg_wr_ch_o   <= '0;
    end else if (gnt_any) begin
      ptr               <= gnt_idx;
      bus.reg_wr_en_o   <= 1'b1;
      bus.reg_wr_data_o <= slot_data[gnt_idx];
      bus.reg_wr_ch_o   <= gnt_idx;
    end else begin
      bus.reg_wr_en_o <= 1'b0;
    end
  end

  // Sticky overflow flags; a new set beats a same-cycle clear
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf <= '0;
    end else begin
      ovf <= (bus.ovf_clr_i ? '0 : ovf) | ovf_set;
    end
  end

  assign bus.ovf_o = ovf;

endmodule

// File: tb/tb_meas_wr_arbiter.sv
// Scoreboard bench for meas_wr_arbiter.
// Directed cases plus random traffic against a queue-based model.
module tb_meas_wr_arbiter;
  import dfm_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  meas_wr_arbiter_if bus ();

  meas_wr_arbiter dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  ch;
    logic [63:0] data;
  } wr_t;

  wr_t             exp_q[$];
  logic            m_pend [N_CH];
  logic [63:0]     m_data [N_CH];
  int              m_last;
  logic [N_CH-1:0] m_ovf;
  logic            exp_now;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Reference: pending set per channel, one issue per cycle in RR order
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        m_pend[i] = 1'b0;
        m_data[i] = '0;
      end
      m_last  = N_CH - 1;
      m_ovf   = '0;
      exp_now = 1'b0;
      exp_q.delete();
    end else begin
      int g;
      logic [N_CH-1:0] setv;
      g = -1;
      for (int k = 1; k <= N_CH; k++) begin
        int c;
        c = (m_last + k) % N_CH;
        if (g < 0 && m_pend[c]) g = c;
      end
      exp_now = (g >= 0);
      if (g >= 0) begin
        exp_q.push_back('{ch: 8'(g), data: m_data[g]});
        m_last    = g;
        m_pend[g] = 1'b0;
      end
      setv = '0;
      for (int i = 0; i < N_CH; i++) begin
        if (bus.raw_wr_en_i[i]) begin
          if (m_pend[i]) setv[i] = 1'b1;
          m_pend[i] = 1'b1;
          m_data[i] = bus.raw_wr_data_i[i];
        end
      end
      m_ovf = (bus.ovf_clr_i ? '0 : m_ovf) | setv;
    end
  end

  // Monitor: compare every presented write and the flags
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_en", 64'(bus.reg_wr_en_o), 64'd0);
      chk("rst_data", bus.reg_wr_data_o, 64'd0);
      chk("rst_ch", 64'(bus.reg_wr_ch_o), 64'd0);
      chk("rst_ovf", 64'(bus.ovf_o), 64'd0);
    end else begin
      chk("wr_en", 64'(bus.reg_wr_en_o), 64'(exp_now));
      chk("ovf", 64'(bus.ovf_o), 64'(m_ovf));
      if (bus.reg_wr_en_o) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_wr: got ch %0d want none",
                   bus.reg_wr_ch_o);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_ch", 64'(bus.reg_wr_ch_o), 64'(e.ch));
          chk("wr_data", bus.reg_wr_data_o, e.data);
        end
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    bus.raw_wr_en_i = '0;
    bus.ovf_clr_i   = 1'b0;
  endtask

  task automatic put(input logic [N_CH-1:0] en,
                     input logic [63:0]     base);
    @(negedge clk);
    bus.raw_wr_en_i = en;
    bus.ovf_clr_i   = 1'b0;
    for (int i = 0; i < N_CH; i++)
      bus.raw_wr_data_i[i] = base * 64'(i);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    bus.raw_wr_en_i = '0;
    bus.ovf_clr_i   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.raw_wr_en_i = '0;
    bus.ovf_clr_i   = 1'b0;
    for (int i = 0; i < N_CH; i++)
      bus.raw_wr_data_i[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle();

    // T1 single write on ch2
    @(negedge clk);
    bus.raw_wr_en_i = 5'b00100;
    bus.raw_wr_data_i[2] = 64'h0123_4567_89AB_CDEF;
    idle();
    repeat (4) idle();

    // T2 all channels at once
    put(5'b11111, 64'h1111);
    repeat (8) idle();
    chk("t2_ovf", 64'(bus.ovf_o), 64'd0);

    // T3 fairness ch0/ch3 twice
    put(5'b01001, 64'h3000_0001);
    repeat (2) idle();
    put(5'b01001, 64'h3000_0002);
    repeat (6) idle();

    // T4 overflow on ch4, then clear
    do_reset();
    put(5'b11111, 64'h1111);
    idle();
    @(negedge clk);
    bus.raw_wr_en_i = 5'b10000;
    bus.raw_wr_data_i[4] = 64'hDEAD;
    repeat (6) idle();
    chk("t4_ovf", 64'(bus.ovf_o), 64'h10);
    @(negedge clk);
    bus.ovf_clr_i = 1'b1;
    idle();
    chk("t4_clr", 64'(bus.ovf_o), 64'd0);

    // T5 capture/grant collision on ch0
    @(negedge clk);
    bus.raw_wr_en_i = 5'b00001;
    bus.raw_wr_data_i[0] = 64'hAAAA;
    @(negedge clk);
    bus.raw_wr_data_i[0] = 64'hBBBB;
    repeat (4) idle();
    chk("t5_ovf", 64'(bus.ovf_o), 64'd0);

    // T6 reset mid-operation
    put(5'b11111, 64'h1111);
    idle();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t6_quiet", 64'(bus.reg_wr_en_o), 64'd0);
    end

    // Random traffic with occasional clears
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      bus.raw_wr_en_i = N_CH'($urandom & $urandom);
      bus.ovf_clr_i   = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N_CH; i++)
        bus.raw_wr_data_i[i] = {$urandom, $urandom};
    end
    repeat (12) idle();
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
